// File: rtl/cpu_clock_sequencer_if.sv
// Bundle between the turbo/config logic (master) and the CPU clock
// sequencer (slave): speed request, stretch control and status in one
// direction; CPU clock, edge strobes and applied speed in the other.
interface cpu_clock_sequencer_if;
   logic [1:0] turbo_req;
   logic       stretch;
   logic       status_clr;
   logic       clk_cpu;
   logic       cpu_rise;
   logic       cpu_fall;
   logic [1:0] turbo_cur;
   logic       switch_pending;
   logic       stretch_timeout;

   modport master (
      output turbo_req, stretch, status_clr,
      input  clk_cpu, cpu_rise, cpu_fall, turbo_cur, switch_pending, stretch_timeout
   );

   modport slave (
      input  turbo_req, stretch, status_clr,
      output clk_cpu, cpu_rise, cpu_fall, turbo_cur, switch_pending, stretch_timeout
   );
endinterface

// File: rtl/cpu_clock_sequencer.sv
// Z80 clock generator running off clk28. Produces a 3.5/7/14 MHz CPU clock
// with one-cycle rise/fall strobes, applies speed changes only at whole
// period boundaries (with a dwell lock-out between switches), and can hold
// the low phase for a bounded number of cycles when a slow resource asks.
module cpu_clock_sequencer #(
   parameter int DWELL_CYCLES = 256,
   parameter int STRETCH_MAX  = 64
) (
   input  logic                    clk28,
   input  logic                    rst,
   cpu_clock_sequencer_if.slave    bus
);

   localparam int DWELL_W = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
   localparam int STR_W   = $clog2(STRETCH_MAX + 1);
   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES);
   localparam logic [STR_W-1:0]   STR_LIMIT  = STR_W'(STRETCH_MAX);

   typedef enum logic {
      ST_RUN,
      ST_STRETCH
   } state_t;

   // Half period in clk28 cycles for an applied speed code.
   function automatic logic [2:0] half_of(input logic [1:0] spd);
      case (spd)
         2'd1:    half_of = 3'd2;
         2'd2:    half_of = 3'd1;
         default: half_of = 3'd4;
      endcase
   endfunction

   // Last phase index (2H-1) for an applied speed code.
   function automatic logic [2:0] last_of(input logic [1:0] spd);
      case (spd)
         2'd1:    last_of = 3'd3;
         2'd2:    last_of = 3'd1;
         default: last_of = 3'd7;
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [2:0]         ph_q, ph_d;
   logic [1:0]         turbo_cur_q, turbo_cur_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [STR_W-1:0]   stretch_cnt_q, stretch_cnt_d;
   logic               clk_cpu_q, clk_cpu_d;
   logic               cpu_rise_q, cpu_rise_d;
   logic               cpu_fall_q, cpu_fall_d;
   logic               timeout_q, timeout_d;

   logic [1:0]         eff_req;
   logic               pending;
   logic               wrap;
   logic [STR_W-1:0]   stretch_cnt_inc;

   // Reserved request code behaves as the slowest speed.
   always_comb begin
      eff_req = (bus.turbo_req == 2'd3) ? 2'd0 : bus.turbo_req;
      pending = (eff_req != turbo_cur_q);
   end

   // Phase sequencing, stretch handling, wrap decision and registered-output next values.
   always_comb begin
      state_d         = state_q;
      ph_d            = ph_q;
      turbo_cur_d     = turbo_cur_q;
      dwell_d         = (dwell_q != '0) ? dwell_q - DWELL_W'(1) : '0;
      stretch_cnt_d   = stretch_cnt_q;
      timeout_d       = timeout_q & ~bus.status_clr;
      wrap            = 1'b0;
      stretch_cnt_inc = stretch_cnt_q + STR_W'(1);

      case (state_q)
         ST_RUN: begin
            if (ph_q >= last_of(turbo_cur_q)) begin
               if (bus.stretch) begin
                  state_d       = ST_STRETCH;
                  stretch_cnt_d = '0;
               end else begin
                  wrap = 1'b1;
               end
            end else begin
               ph_d = ph_q + 3'd1;
            end
         end
         ST_STRETCH: begin
            // The limit is checked first so a release coinciding with the
            // limit still records the forced termination.
            if (stretch_cnt_inc >= STR_LIMIT) begin
               timeout_d = 1'b1;
               wrap      = 1'b1;
            end else if (!bus.stretch) begin
               wrap = 1'b1;
            end else begin
               stretch_cnt_d = stretch_cnt_inc;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Speed may only change here, after the old low phase has fully elapsed.
      if (wrap) begin
         if (pending && (dwell_q == '0)) begin
            turbo_cur_d = eff_req;
            dwell_d     = DWELL_LOAD;
         end
         ph_d    = 3'd0;
         state_d = ST_RUN;
      end

      clk_cpu_d  = (ph_d < half_of(turbo_cur_d));
      cpu_rise_d = wrap;
      cpu_fall_d = (ph_d == half_of(turbo_cur_d)) && (ph_d != ph_q);
   end

   // State and output registers; reset parks the phase at the wrap point.
   always_ff @(posedge clk28 or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         ph_q          <= 3'd7;
         turbo_cur_q   <= 2'd0;
         dwell_q       <= '0;
         stretch_cnt_q <= '0;
         clk_cpu_q     <= 1'b0;
         cpu_rise_q    <= 1'b0;
         cpu_fall_q    <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ph_q          <= ph_d;
         turbo_cur_q   <= turbo_cur_d;
         dwell_q       <= dwell_d;
         stretch_cnt_q <= stretch_cnt_d;
         clk_cpu_q     <= clk_cpu_d;
         cpu_rise_q    <= cpu_rise_d;
         cpu_fall_q    <= cpu_fall_d;
         timeout_q     <= timeout_d;
      end
   end

   assign bus.clk_cpu         = clk_cpu_q;
   assign bus.cpu_rise        = cpu_rise_q;
   assign bus.cpu_fall        = cpu_fall_q;
   assign bus.turbo_cur       = turbo_cur_q;
   assign bus.switch_pending  = pending;
   assign bus.stretch_timeout = timeout_q;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Directed bench for cpu_clock_sequencer: a vector table for reset release
// and a 3.5 -> 14 MHz switch, then hand-written sequences for reset
// mid-phase, dwell lock-out, stretch, timeout and the reserved speed code.
module tb_cpu_clock_sequencer;

   logic clk28;
   logic rst;
   int   errors;
   int   checks;
   int   cyc;

   cpu_clock_sequencer_if bus();

   cpu_clock_sequencer #(
      .DWELL_CYCLES (256),
      .STRETCH_MAX  (64)
   ) dut (
      .clk28 (clk28),
      .rst   (rst),
      .bus   (bus)
   );

   initial begin
      clk28 = 1'b0;
      forever #5 clk28 = ~clk28;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0] req;
      logic       clk;
      logic       rise;
      logic       fall;
      logic [1:0] cur;
      logic       pend;
   } vec_t;

   vec_t vecs[28];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk28);
      #1;
      cyc++;
   endtask

   task automatic do_reset(input logic [1:0] req);
      bus.turbo_req  = req;
      bus.stretch    = 1'b0;
      bus.status_clr = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      cyc = 0;
   endtask

   // Steps until a rise (want_fall=0) or fall (want_fall=1) strobe, bounded.
   task automatic wait_strobe(input bit want_fall, input int limit, input string name, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         step();
         if (want_fall ? bus.cpu_fall : bus.cpu_rise) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got no strobe within %0d cycles, want strobe", name, limit);
      end
   endtask

   initial begin
      int sw_at;
      int bad_pend;
      int early;
      int f_at;
      int r_at;
      int ph;

      errors = 0;
      checks = 0;
      cyc    = 0;

      // Reset release at 3.5 MHz: period 8 (4 high, 4 low), then request
      // 14 MHz while ph = 2; the 8-cycle period finishes before 2-cycle periods start.
      vecs[0]  = '{2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
      vecs[1]  = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[2]  = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[3]  = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[4]  = '{2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
      vecs[5]  = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[6]  = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[7]  = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[8]  = '{2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
      vecs[9]  = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[10] = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[11] = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[12] = '{2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
      vecs[13] = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[14] = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[15] = '{2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[16] = '{2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
      vecs[17] = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[18] = '{2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
      vecs[19] = '{2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
      vecs[20] = '{2'd2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1};
      vecs[21] = '{2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
      vecs[22] = '{2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
      vecs[23] = '{2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
      vecs[24] = '{2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
      vecs[25] = '{2'd2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0};
      vecs[26] = '{2'd2, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
      vecs[27] = '{2'd2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0};

      // Reset state.
      bus.turbo_req  = 2'd0;
      bus.stretch    = 1'b0;
      bus.status_clr = 1'b0;
      rst = 1'b1;
      repeat (3) step();
      check("rst_clk_cpu",  bus.clk_cpu, 0);
      check("rst_rise",     bus.cpu_rise, 0);
      check("rst_fall",     bus.cpu_fall, 0);
      check("rst_cur",      bus.turbo_cur, 0);
      check("rst_pending",  bus.switch_pending, 0);
      check("rst_timeout",  bus.stretch_timeout, 0);
      rst = 1'b0;
      cyc = 0;

      for (int i = 0; i < 28; i++) begin
         bus.turbo_req = vecs[i].req;
         step();
         $display("vec %0d: req=%0d clk_cpu=%0b rise=%0b fall=%0b cur=%0d pend=%0b",
                  i + 1, vecs[i].req, bus.clk_cpu, bus.cpu_rise, bus.cpu_fall,
                  bus.turbo_cur, bus.switch_pending);
         check($sformatf("vec%0d_clk_cpu", i + 1), bus.clk_cpu, vecs[i].clk);
         check($sformatf("vec%0d_rise", i + 1),    bus.cpu_rise, vecs[i].rise);
         check($sformatf("vec%0d_fall", i + 1),    bus.cpu_fall, vecs[i].fall);
         check($sformatf("vec%0d_cur", i + 1),     bus.turbo_cur, vecs[i].cur);
         check($sformatf("vec%0d_pend", i + 1),    bus.switch_pending, vecs[i].pend);
      end

      // Reset asserted during a 14 MHz high phase, released 5 cycles later.
      step();
      check("pre_rst_high", bus.clk_cpu, 1);
      bus.turbo_req = 2'd0;
      rst = 1'b1;
      #1;
      check("async_rst_clk_cpu", bus.clk_cpu, 0);
      check("async_rst_cur",     bus.turbo_cur, 0);
      check("async_rst_rise",    bus.cpu_rise, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("in_rst%0d_clk_cpu", i), bus.clk_cpu, 0);
         check($sformatf("in_rst%0d_fall", i),    bus.cpu_fall, 0);
         check($sformatf("in_rst%0d_pending", i), bus.switch_pending, 0);
      end
      rst = 1'b0;
      cyc = 0;
      step();
      check("post_rst_rise",    bus.cpu_rise, 1);
      check("post_rst_clk_cpu", bus.clk_cpu, 1);
      check("post_rst_cur",     bus.turbo_cur, 0);
      repeat (4) step();
      check("post_rst_fall_c5", bus.cpu_fall, 1);
      $display("seq reset-mid-high: done");

      // Dwell lock-out: switch to 7 MHz at cycle 1, request 3.5 MHz at cycle 21.
      // Wraps are every 4 cycles; the dwell counter first reads 0 at the wrap on cycle 261.
      do_reset(2'd1);
      step();
      check("dwell_first_switch_cur",  bus.turbo_cur, 1);
      check("dwell_first_switch_rise", bus.cpu_rise, 1);
      repeat (19) step();
      bus.turbo_req = 2'd0;
      sw_at    = -1;
      bad_pend = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (bus.turbo_cur == 2'd0) begin
            sw_at = cyc;
            break;
         end
         if (!bus.switch_pending) bad_pend++;
      end
      check("dwell_second_switch_cycle", sw_at, 261);
      check("dwell_pending_held",        bad_pend, 0);
      check("dwell_switch_rise",         bus.cpu_rise, 1);
      repeat (3) step();
      check("dwell_new_high_c3", bus.clk_cpu, 1);
      step();
      check("dwell_new_fall_c4", bus.cpu_fall, 1);
      $display("seq dwell: second switch at cycle %0d", sw_at);

      // Stretch at 7 MHz: asserted from the ph=2 cycle for 10 cycles.
      // The ph=2 sample does nothing, 9 held cycles at ph=3 -> low phase 2+9 = 11.
      do_reset(2'd1);
      repeat (3) step();
      check("stretch_fall_c3", bus.cpu_fall, 1);
      bus.stretch = 1'b1;
      early = -1;
      repeat (10) begin
         step();
         if (bus.cpu_rise && early < 0) early = cyc;
      end
      check("stretch10_no_early_rise", early, -1);
      bus.stretch = 1'b0;
      wait_strobe(1'b0, 5, "stretch10_rise", r_at);
      check("stretch10_low_len", r_at - 3, 11);
      check("stretch10_no_timeout", bus.stretch_timeout, 0);
      $display("seq stretch10: low phase %0d cycles", r_at - 3);

      // Stretch runs into the 64-cycle limit, released in the very cycle of the timeout.
      wait_strobe(1'b1, 20, "timeout_fall", f_at);
      bus.stretch = 1'b1;
      early = -1;
      repeat (65) begin
         step();
         if (bus.cpu_rise && early < 0) early = cyc;
      end
      check("timeout_no_early_rise", early, -1);
      check("timeout_flag_before", bus.stretch_timeout, 0);
      bus.stretch = 1'b0;
      step();
      check("timeout_rise", bus.cpu_rise, 1);
      check("timeout_flag_set", bus.stretch_timeout, 1);
      check("timeout_low_len", cyc - f_at, 66);
      bus.status_clr = 1'b1;
      step();
      check("timeout_clr", bus.stretch_timeout, 0);
      bus.status_clr = 1'b0;
      $display("seq timeout: low phase %0d cycles", cyc - 1 - f_at);

      // status_clr held while another timeout fires: the flag is set in that cycle.
      wait_strobe(1'b1, 20, "clr_vs_timeout_fall", f_at);
      bus.stretch    = 1'b1;
      bus.status_clr = 1'b1;
      wait_strobe(1'b0, 100, "clr_vs_timeout_rise", r_at);
      check("clr_vs_timeout_low_len", r_at - f_at, 66);
      check("clr_vs_timeout_flag",    bus.stretch_timeout, 1);
      step();
      check("clr_vs_timeout_cleared", bus.stretch_timeout, 0);
      bus.stretch    = 1'b0;
      bus.status_clr = 1'b0;
      $display("seq clr-vs-timeout: done");

      // Reserved request code behaves as 3.5 MHz with nothing pending.
      do_reset(2'd3);
      for (int n = 1; n <= 17; n++) begin
         step();
         ph = (n - 1) % 8;
         check($sformatf("rsv_c%0d_clk_cpu", n), bus.clk_cpu, (ph < 4) ? 1 : 0);
         check($sformatf("rsv_c%0d_rise", n),    bus.cpu_rise, (ph == 0) ? 1 : 0);
         check($sformatf("rsv_c%0d_fall", n),    bus.cpu_fall, (ph == 4) ? 1 : 0);
         check($sformatf("rsv_c%0d_cur", n),     bus.turbo_cur, 0);
         check($sformatf("rsv_c%0d_pend", n),    bus.switch_pending, 0);
      end
      $display("seq reserved-code: done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_clock_sequencer.md
Name: cpu_clock_sequencer

Overview:
- Generates the Z80 clock and its edge strobes from clk28 at 3.5/7/14 MHz.
- Sequences speed changes requested by the turbo selection logic so they only take effect on whole CPU-clock period boundaries, with a dwell lock-out to suppress chatter.
- Provides a bounded stretch of the CPU clock low phase for slow resources (contention, flash writes).
- Sits between the turbo/config logic and the CPU clock pin; all downstream CPU-timed logic uses its strobes.

Parameters:
- DWELL_CYCLES, 256, minimum clk28 cycles between two applied speed switches; 0 disables the lock-out.
- STRETCH_MAX, 64, maximum clk28 cycles a single low phase may be extended by stretch; must be at least 1.

Ports:
- clk28  input  1  28 MHz system clock; only clock.
- rst  input  1  asynchronous, active-high reset.
- turbo_req  input  2  requested speed: 0 = 3.5 MHz, 1 = 7 MHz, 2 = 14 MHz, 3 = reserved, treated as 0.
- stretch  input  1  hold the CPU clock low at the end of the current period.
- status_clr  input  1  synchronous clear of stretch_timeout.
- clk_cpu  output  1  registered CPU clock.
- cpu_rise  output  1  one-clk28 pulse in the cycle clk_cpu becomes 1.
- cpu_fall  output  1  one-clk28 pulse in the cycle clk_cpu becomes 0.
- turbo_cur  output  2  speed currently applied; 0, 1 or 2 only.
- switch_pending  output  1  turbo_req differs from turbo_cur and is not yet applied.
- stretch_timeout  output  1  sticky flag: a stretch was force-terminated.

Behaviour:
- Half period H: 4 for speed 0, 2 for speed 1, 1 for speed 2.
- Phase counter ph is 3 bits and counts 0..2H-1. clk_cpu is 1 for ph < H and 0 otherwise. Outputs are registered from the next-state ph.
- cpu_rise is 1 in the cycle ph enters 0; cpu_fall is 1 in the cycle ph enters H.
- Reset values: ph = 7; turbo_cur = 0; clk_cpu = 0; cpu_rise = 0; cpu_fall = 0; switch_pending = 0; stretch_timeout = 0; dwell counter = 0; stretch counter = 0.
- First clk28 edge after rst deasserts: ph = 0, clk_cpu = 1, cpu_rise = 1.
- State machine:
  - RUN: ph advances each clk28. At ph = 2H-1, if stretch = 1, go to STRETCH and ph holds. Otherwise take the wrap decision.
  - STRETCH: ph holds at 2H-1 and clk_cpu stays 0. The stretch counter increments each cycle. Exit when stretch = 0, or when the counter reaches STRETCH_MAX; the latter sets stretch_timeout. On exit, take the wrap decision and return to RUN.
  - Wrap decision: if switch_pending = 1 and the dwell counter = 0, load turbo_cur from the effective request and reload the dwell counter with DWELL_CYCLES. Then ph = 0 with the new H, and cpu_rise = 1.
- Period integrity: a switch never shortens or truncates a high or low phase. The old-speed low phase completes before the new-speed high phase begins.
- Dwell counter: decrements to 0 every clk28, including during STRETCH.
- switch_pending:
  - Combinational from the effective request (reserved code mapped to 0) versus turbo_cur.
  - Request changes during a period are sampled only at the wrap decision.
  - A request that reverts before the wrap causes no switch.
- Stretch counter: cleared on entry to STRETCH. A stretch asserted while ph < 2H-1 has no effect until ph reaches 2H-1.
- Simultaneous events:
  - Timeout and stretch deasserting in the same cycle: timeout takes priority and the flag is set.
  - status_clr and a new timeout in the same cycle: the flag stays set.
- rst mid-operation: immediate asynchronous return to reset values. No cpu_fall pulse is generated for the truncated phase.
- Width: the dwell counter is sized to hold DWELL_CYCLES; the stretch counter is sized to hold STRETCH_MAX.

Test Plan:
- Reset release, turbo_req = 0: clk_cpu period 8 clk28 (4 high, 4 low). cpu_rise at cycles 1, 9, 17; cpu_fall at 5, 13.
- turbo_req 0→2 while ph = 2, dwell counter = 0: current 8-cycle period completes. Next period is 2 cycles. turbo_cur = 2 at the wrap; switch_pending is 1 until then.
- DWELL_CYCLES = 256, request 0→1 then 1→0 twenty cycles after the switch: second switch is applied only at the first wrap with the dwell counter at 0, i.e. at or after cycle 256 from the first switch. switch_pending = 1 meanwhile.
- Speed 1, stretch held for 10 clk28 at ph = 3: low phase lasts 11 cycles; no timeout. Stretch held for 200 cycles with STRETCH_MAX = 64: low phase ends after 64 extra cycles and stretch_timeout = 1. status_clr clears it.
- turbo_req = 3: turbo_cur stays 0, switch_pending stays 0, period 8.
- rst asserted mid-high phase at 14 MHz, released 5 cycles later: outputs at reset values while asserted. Resumes at speed 0 with cpu_rise on the first edge after release.
